// File: rtl/cbb_popcount_pkg.sv
// Shared helpers for the cbb_count_ones_pipe population-count engine:
// per-chunk count width and the saturation ceiling of an N-bit accumulator.
package cbb_popcount_pkg;

    // A CHUNK_W-bit chunk holds at most CHUNK_W ones
    function automatic int chunk_cnt_w(input int chunk_w);
        return $clog2(chunk_w) + 1;
    endfunction

    // All-ones value of a w-bit field (1 <= w <= 64)
    function automatic logic [63:0] sat_max(input int w);
        return ~64'd0 >> (64 - w);
    endfunction

endpackage

// File: rtl/cbb_chunk_popcnt.sv
// Combinational one-counter for a single CHUNK_W-bit slice of a beat.
module cbb_chunk_popcnt
    import cbb_popcount_pkg::*;
#(
    parameter int CHUNK_W = 8,
    parameter int CNT_W   = chunk_cnt_w(CHUNK_W)
) (
    input  logic [CHUNK_W-1:0] bits,
    output logic [CNT_W-1:0]   count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < CHUNK_W; i++) begin
            count = count + CNT_W'(bits[i]);
        end
    end

endmodule

// File: rtl/cbb_count_ones_pipe.sv
// Two-stage streaming popcount with per-frame saturating running total.
// Define CBB_COUNT_ONES_PIPE_MASK_EN to add the in_mask bit-select port.
module cbb_count_ones_pipe
    import cbb_popcount_pkg::*;
#(
    parameter int WIDTH     = 64,
    parameter int CHUNK_W   = 8,
    parameter int ACC_W     = 16,
    parameter int OUT_CNT_W = $clog2(WIDTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
`ifdef CBB_COUNT_ONES_PIPE_MASK_EN
    input  logic [WIDTH-1:0]     in_mask,
`endif
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_CNT_W-1:0] out_count,
    output logic [ACC_W-1:0]     out_total,
    output logic                 out_last,
    output logic                 out_sat
);

    localparam int N_CHUNK = WIDTH / CHUNK_W;
    localparam int CNT_W   = chunk_cnt_w(CHUNK_W);
    localparam int SUM_W   = ((ACC_W > OUT_CNT_W) ? ACC_W : OUT_CNT_W) + 1;

    localparam logic [ACC_W-1:0] SAT_MAX     = ACC_W'(sat_max(ACC_W));
    localparam logic [SUM_W-1:0] SAT_MAX_EXT = SUM_W'(sat_max(ACC_W));

    logic [WIDTH-1:0] count_bits;

`ifdef CBB_COUNT_ONES_PIPE_MASK_EN
    assign count_bits = in_data & in_mask;
`else
    assign count_bits = in_data;
`endif

    // ---------------- S1: chunk counters ----------------
    logic [N_CHUNK-1:0][CNT_W-1:0] chunk_cnt;
    logic [N_CHUNK-1:0][CNT_W-1:0] s1_cnt;
    logic                          s1_valid;
    logic                          s1_last;

    for (genvar g = 0; g < N_CHUNK; g++) begin : g_chunk
        cbb_chunk_popcnt #(
            .CHUNK_W (CHUNK_W),
            .CNT_W   (CNT_W)
        ) u_chunk (
            .bits  (count_bits[g*CHUNK_W +: CHUNK_W]),
            .count (chunk_cnt[g])
        );
    end

    logic s1_load;
    logic s2_load;

    // S2 takes a beat when it is empty or its result leaves this cycle
    assign s2_load  = s1_valid && (!out_valid || out_ready);
    assign in_ready = !s1_valid || s2_load;
    assign s1_load  = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_cnt   <= '0;
            s1_last  <= 1'b0;
        end else if (s1_load) begin
            s1_valid <= 1'b1;
            s1_cnt   <= chunk_cnt;
            s1_last  <= in_last;
        end else if (s2_load) begin
            s1_valid <= 1'b0;
        end
    end

    // ---------------- S2: adder tree + accumulator ----------------
    logic [OUT_CNT_W-1:0] beat_sum;
    logic [OUT_CNT_W-1:0] tree [N_CHUNK];

    always_comb begin
        for (int i = 0; i < N_CHUNK; i++) begin
            tree[i] = OUT_CNT_W'(s1_cnt[i]);
        end
        for (int step = 1; step < N_CHUNK; step = step * 2) begin
            for (int i = 0; i + step < N_CHUNK; i = i + 2 * step) begin
                tree[i] = tree[i] + tree[i+step];
            end
        end
        beat_sum = tree[0];
    end

    logic [ACC_W-1:0] acc;
    logic             sticky_sat;
    logic [SUM_W-1:0] sum_ext;
    logic             ovf;
    logic [ACC_W-1:0] total_sat;
    logic             sat_next;

    always_comb begin
        sum_ext   = SUM_W'(acc) + SUM_W'(beat_sum);
        ovf       = sum_ext > SAT_MAX_EXT;
        total_sat = ovf ? SAT_MAX : sum_ext[ACC_W-1:0];
        sat_next  = sticky_sat || ovf;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_count  <= '0;
            out_total  <= '0;
            out_last   <= 1'b0;
            out_sat    <= 1'b0;
            acc        <= '0;
            sticky_sat <= 1'b0;
        end else if (s2_load) begin
            out_valid <= 1'b1;
            out_count <= beat_sum;
            out_total <= total_sat;
            out_last  <= s1_last;
            out_sat   <= sat_next;
            // A closing beat leaves a clean slate for the next frame
            if (s1_last) begin
                acc        <= '0;
                sticky_sat <= 1'b0;
            end else begin
                acc        <= total_sat;
                sticky_sat <= sat_next;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cbb_count_ones_pipe.sv
// Bench for cbb_count_ones_pipe: ACC_W=16 and ACC_W=8 instances share stimulus.
module tb_cbb_count_ones_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_last;
    logic        out_ready;
    logic [63:0] in_data;
    logic [63:0] mask;

    logic        in_ready,  in_ready8;
    logic        out_valid, out_valid8;
    logic [6:0]  out_count, out_count8;
    logic [15:0] out_total;
    logic [7:0]  out_total8;
    logic        out_last,  out_last8;
    logic        out_sat,   out_sat8;

    always #5 clk = ~clk;

    cbb_count_ones_pipe #(.WIDTH(64), .CHUNK_W(8), .ACC_W(16)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
`ifdef CBB_COUNT_ONES_PIPE_MASK_EN
        .in_mask   (mask),
`endif
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_count (out_count),
        .out_total (out_total),
        .out_last  (out_last),
        .out_sat   (out_sat)
    );

    cbb_count_ones_pipe #(.WIDTH(64), .CHUNK_W(8), .ACC_W(8)) u_dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready8),
        .in_data   (in_data),
`ifdef CBB_COUNT_ONES_PIPE_MASK_EN
        .in_mask   (mask),
`endif
        .in_last   (in_last),
        .out_valid (out_valid8),
        .out_ready (out_ready),
        .out_count (out_count8),
        .out_total (out_total8),
        .out_last  (out_last8),
        .out_sat   (out_sat8)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- scoreboard model ----------------
    typedef struct {
        int cnt;
        int t16;
        int t8;
        bit s16;
        bit s8;
        bit last;
    } exp_t;

    exp_t q[$];
    int   a16 = 0, a8 = 0;
    bit   st16 = 0, st8 = 0;
    int   n_acc = 0, n_emit = 0;
    bit   stall_prev = 0;
    logic [6:0]  p_cnt;
    logic [15:0] p_tot;
    logic [7:0]  p_tot8;
    logic        p_sat, p_sat8, p_last;

    function automatic exp_t model_push(input logic [63:0] d, input bit l);
        exp_t e;
        int   s;
`ifdef CBB_COUNT_ONES_PIPE_MASK_EN
        e.cnt = $countones(d & mask);
`else
        e.cnt = $countones(d);
`endif
        s     = a16 + e.cnt;
        e.t16 = (s > 65535) ? 65535 : s;
        e.s16 = st16 || (s > 65535);
        s     = a8 + e.cnt;
        e.t8  = (s > 255) ? 255 : s;
        e.s8  = st8 || (s > 255);
        e.last = l;
        a16  = l ? 0 : e.t16;
        st16 = l ? 0 : e.s16;
        a8   = l ? 0 : e.t8;
        st8  = l ? 0 : e.s8;
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        int   inflight;
        if (!rst_n) begin
            q.delete();
            a16 = 0; a8 = 0; st16 = 0; st8 = 0;
            n_acc = 0; n_emit = 0; stall_prev = 0;
        end else begin
            inflight = n_acc - n_emit;
            chk("in_ready", in_ready, !(inflight == 2 && !out_ready));
            chk("in_ready8", in_ready8, in_ready);
            chk("out_valid8", out_valid8, out_valid);
            if (stall_prev) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_count", out_count, p_cnt);
                chk("hold_total", out_total, p_tot);
                chk("hold_total8", out_total8, p_tot8);
                chk("hold_sat", out_sat, p_sat);
                chk("hold_sat8", out_sat8, p_sat8);
                chk("hold_last", out_last, p_last);
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("spurious_beat", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("sb_count", out_count, e.cnt);
                    chk("sb_count8", out_count8, e.cnt);
                    chk("sb_total", out_total, e.t16);
                    chk("sb_total8", out_total8, e.t8);
                    chk("sb_sat", out_sat, e.s16);
                    chk("sb_sat8", out_sat8, e.s8);
                    chk("sb_last", out_last, e.last);
                    chk("sb_last8", out_last8, e.last);
                end
                n_emit++;
            end
            if (in_valid && in_ready) begin
                q.push_back(model_push(in_data, in_last));
                n_acc++;
            end
            stall_prev = out_valid && !out_ready;
            p_cnt  = out_count;  p_tot  = out_total; p_tot8 = out_total8;
            p_sat  = out_sat;    p_sat8 = out_sat8;  p_last = out_last;
        end
    end

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 20 && n_acc != n_emit; k++) tick();
        chk("drain_left", n_acc - n_emit, 0);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [63:0] data;
        logic        last;
        int          cnt;
        int          t16;
        int          t8;
        bit          s16;
        bit          s8;
    } vec_t;

    localparam logic [63:0] ONES = '1;
    localparam int NV = 10;
    vec_t tbl [NV];

    initial begin
        bit pat [4];

        tbl[0] = '{64'h0, 1'b0, 0, 0, 0, 0, 0};
        tbl[1] = '{ONES, 1'b0, 64, 64, 64, 0, 0};
        tbl[2] = '{64'h0F0F_0000_0000_0001, 1'b1, 9, 73, 73, 0, 0};
        tbl[3] = '{64'h3, 1'b1, 2, 2, 2, 0, 0};
        tbl[4] = '{ONES, 1'b0, 64, 64, 64, 0, 0};
        tbl[5] = '{ONES, 1'b0, 64, 128, 128, 0, 0};
        tbl[6] = '{ONES, 1'b0, 64, 192, 192, 0, 0};
        tbl[7] = '{ONES, 1'b0, 64, 256, 255, 0, 1};
        tbl[8] = '{ONES, 1'b1, 64, 320, 255, 0, 1};
        tbl[9] = '{64'hFF, 1'b1, 8, 8, 8, 0, 0};

        rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        in_data = '0; out_ready = 1'b1; mask = '1;
        #2;
        chk("rst_valid", out_valid, 0);
        chk("rst_count", out_count, 0);
        chk("rst_total", out_total, 0);
        chk("rst_last", out_last, 0);
        chk("rst_sat", out_sat, 0);
        chk("rst_total8", out_total8, 0);
        tick();
        tick();
        rst_n = 1'b1;
        chk("post_rst_ready", in_ready, 1);

        // back-to-back beats, out_ready high: result two cycles later
        for (int c = 0; c < NV + 2; c++) begin
            if (c < NV) begin
                in_valid = 1'b1;
                in_data  = tbl[c].data;
                in_last  = tbl[c].last;
            end else begin
                in_valid = 1'b0;
                in_data  = {$urandom(), $urandom()};
                in_last  = 1'b1;
            end
            if (c >= 2) begin
                chk("vec_valid", out_valid, 1);
                chk("vec_count", out_count, tbl[c-2].cnt);
                chk("vec_total", out_total, tbl[c-2].t16);
                chk("vec_total8", out_total8, tbl[c-2].t8);
                chk("vec_sat", out_sat, tbl[c-2].s16);
                chk("vec_sat8", out_sat8, tbl[c-2].s8);
                chk("vec_last", out_last, tbl[c-2].last);
            end else begin
                chk("vec_lat_valid", out_valid, 0);
            end
            tick();
        end
        chk("idle_valid", out_valid, 0);
        drain();

        // mask / full-width count of one all-ones beat
        in_valid = 1'b1; in_data = ONES; in_last = 1'b1; mask = 64'h00FF;
        tick();
        in_valid = 1'b0; mask = '1;
        tick();
`ifdef CBB_COUNT_ONES_PIPE_MASK_EN
        chk("mask_count", out_count, 8);
`else
        chk("nomask_count", out_count, 64);
`endif
        drain();

        // 10 beats with out_ready toggling 1,0,0,1
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        begin
            int sent = 0;
            int cyc  = 0;
            while (sent < 10 && cyc < 100) begin
                in_valid  = 1'b1;
                in_last   = (sent == 9);
                out_ready = pat[cyc % 4];
                in_data   = {32'(sent * 32'h0101_0101), 32'(sent)};
                #1;
                if (in_ready) sent++;
                @(posedge clk);
                #1;
                cyc++;
            end
            chk("stall_all_sent", sent, 10);
        end
        drain();

        // reset with two beats of an open frame in flight
        out_ready = 1'b0;
        in_valid = 1'b1; in_last = 1'b0; in_data = ONES;
        tick();
        in_data = 64'hFFFF;
        tick();
        in_valid = 1'b0;
        chk("pre_rst_valid", out_valid, 1);
        chk("pre_rst_ready", in_ready, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_total", out_total, 0);
        chk("mid_rst_count", out_count, 0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 64'h7; in_last = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        chk("after_rst_valid", out_valid, 1);
        chk("after_rst_total", out_total, 3);
        chk("after_rst_total8", out_total8, 3);
        chk("after_rst_sat", out_sat, 0);
        drain();

        // random valid/ready traffic against the scoreboard
        for (int i = 0; i < 10000; i++) begin
            in_valid  = ($urandom_range(0, 2) != 0);
            in_data   = {$urandom(), $urandom()};
            if ($urandom_range(0, 5) == 0) in_data = ONES;
            in_last   = ($urandom_range(0, 9) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        drain();
        chk("queue_empty", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d",
                 total, bad);
        $fatal(1, "watchdog");
    end

endmodule
